uart_rx_dev: RTL



---
 rtl/uart_rx_dev.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_dev.sv
// UART receiver peripheral: 8N1 deserialiser feeding a small receive FIFO,
// exposed on the device bus as RXDATA / STATUS / CTRL with a level interrupt.
module uart_rx_dev #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int CountW     = PtrW + 1;
  localparam logic [CntW-1:0]   FullLoad  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]   HalfLoad  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CountW-1:0] FullCount = CountW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic              sync_p0, sync_p1, rx_prev;
  logic              fall, tick, shift_en, push_req, frame_set;
  logic [CntW-1:0]   baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CountW-1:0] count_q;
  logic              not_empty, full, pop, push_ok, overrun_set;
  logic              overrun_q, frame_err_q;
  logic [1:0]        ctrl_q;
  logic              wr_status, wr_ctrl, rd_req;
  logic [31:0]       rmux;
  logic              unused;

  assign unused = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i, device_wdata_i[31:4]};

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_p0 <= uart_rx_i;
      sync_p1 <= sync_p0;
      rx_prev <= sync_p1;
    end
  end

  assign fall = rx_prev & ~sync_p1;
  assign tick = (baud_q == '0);

  // Receive FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Receive FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (tick) state_d = sync_p1 ? IDLE : DATA;
      DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Receive FSM outputs: sampling strobes and end-of-frame events
  always_comb begin
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      DATA: shift_en = tick;
      STOP: begin
        push_req  = tick & sync_p1;
        frame_set = tick & ~sync_p1;
      end
      default: ;
    endcase
  end

  // Baud and bit counters: half-bit wait into START, whole bits afterwards
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_q <= '0;
      bit_q  <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (fall) baud_q <= HalfLoad;
      end else if (tick) begin
        baud_q <= FullLoad;
      end else begin
        baud_q <= baud_q - CntW'(1);
      end
      if (state_q == START && tick) bit_q <= '0;
      else if (shift_en)            bit_q <= bit_q + 3'd1;
    end
  end

  // Shift register collecting data bits LSB first
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_q <= {sync_p1, shift_q[7:1]};
  end

  assign rd_req      = device_req_i & ~device_we_i;
  assign wr_status   = device_req_i & device_we_i & (device_addr_i[3:2] == 2'd1);
  assign wr_ctrl     = device_req_i & device_we_i & (device_addr_i[3:2] == 2'd2);
  assign not_empty   = (count_q != '0);
  assign full        = (count_q == FullCount);
  assign pop         = rd_req & (device_addr_i[3:2] == 2'd0) & not_empty;
  assign push_ok     = push_req & (~full | pop);
  assign overrun_set = push_req & full & ~pop;

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)     rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags and control register; a set beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      overrun_q   <= overrun_set | (overrun_q & ~(wr_status & device_wdata_i[2]));
      frame_err_q <= frame_set | (frame_err_q & ~(wr_status & device_wdata_i[3]));
      if (wr_ctrl) ctrl_q <= device_wdata_i[1:0];
    end
  end

  // Read data mux on request-cycle state (pre-pop head, pre-clear flags)
  always_comb begin
    rmux = '0;
    unique case (device_addr_i[3:2])
      2'd0: if (not_empty) rmux[7:0] = mem[rd_ptr];
      2'd1: rmux = {16'h0, 8'(count_q), 4'h0, frame_err_q, overrun_q, full, not_empty};
      2'd2: rmux = {30'h0, ctrl_q};
      default: rmux = '0;
    endcase
  end

  // Registered bus response and interrupt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      irq_o           <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rd_req ? rmux : '0;
      irq_o           <= (ctrl_q[0] & not_empty) | (ctrl_q[1] & (overrun_q | frame_err_q));
    end
  end

endmodule
